// File: rtl/layer_hdr_pkg.sv
// Shared types and constants for the layer header shadow registers.
// Holds the commit FSM state enum and default header register indices.
package layer_hdr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COPY,
        DONE
    } hdrState_t;

    localparam int LAYER_REG_CTRL    = 0;
    localparam int LAYER_REG_ADDR_LO = 1;
    localparam int LAYER_REG_ADDR_HI = 2;
    localparam int LAYER_REG_X       = 3;
    localparam int LAYER_REG_Y       = 4;
    localparam int LAYER_REG_W       = 5;
    localparam int LAYER_REG_H       = 6;
    localparam int LAYER_REG_ALPHA   = 7;

endpackage

// File: rtl/layer_header_bank.sv
// One bank of layer headers: NUM_LAYERS rows of NUM_REGS*DATA_W bits.
// Ports: clk/reset (sync clear), per-register write (regWrEn, regLayer,
// regIdx, regData), full-row write (rowWrEn, rowLayer, rowData),
// combinational row read (rdLayer -> rdRow, zero when out of range).
module layer_header_bank
    import layer_hdr_pkg::*;
#(
    parameter int NUM_LAYERS = 32,
    parameter int NUM_REGS   = 8,
    parameter int DATA_W     = 16,
    localparam int LAYER_W   = $clog2(NUM_LAYERS),
    localparam int REG_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int ROW_W     = NUM_REGS * DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               regWrEn,
    input  logic [LAYER_W-1:0] regLayer,
    input  logic [REG_W-1:0]   regIdx,
    input  logic [DATA_W-1:0]  regData,
    input  logic               rowWrEn,
    input  logic [LAYER_W-1:0] rowLayer,
    input  logic [ROW_W-1:0]   rowData,
    input  logic [LAYER_W-1:0] rdLayer,
    output logic [ROW_W-1:0]   rdRow
);

    logic [ROW_W-1:0] mem [NUM_LAYERS];

    logic regOk;
    logic rowOk;
    int   regOff;

    assign regOk  = regWrEn
                 && (int'(regLayer) < NUM_LAYERS)
                 && (int'(regIdx) < NUM_REGS);
    assign rowOk  = rowWrEn && (int'(rowLayer) < NUM_LAYERS);
    assign regOff = int'(regIdx) * DATA_W;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < NUM_LAYERS; l++) begin
                mem[l] <= '0;
            end
        end else if (rowOk) begin
            mem[rowLayer] <= rowData;
        end else if (regOk) begin
            mem[regLayer][regOff +: DATA_W] <= regData;
        end
    end

    assign rdRow = (int'(rdLayer) < NUM_LAYERS) ? mem[rdLayer] : '0;

endmodule

// File: rtl/layer_header_shadow_regs.sv
// Double-buffered layer headers: host writes land in a shadow bank and
// dirty layers are copied to the active bank at the next frame boundary
// after commit_req. Ports: host write (wr_*), commit_req/frame_start in,
// commit_pending/commit_done out, registered read (rd_* in/out), dirty.
module layer_header_shadow_regs
    import layer_hdr_pkg::*;
#(
    parameter int NUM_LAYERS = 32,
    parameter int NUM_REGS   = 8,
    parameter int DATA_W     = 16,
    localparam int LAYER_W   = $clog2(NUM_LAYERS),
    localparam int REG_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [LAYER_W-1:0]         wr_layer,
    input  logic [REG_W-1:0]           wr_reg,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       commit_req,
    input  logic                       frame_start,
    output logic                       commit_pending,
    output logic                       commit_done,
    input  logic                       rd_en,
    input  logic [LAYER_W-1:0]         rd_layer,
    output logic                       rd_valid,
    output logic [NUM_REGS*DATA_W-1:0] rd_data,
    output logic [NUM_LAYERS-1:0]      dirty
);

    localparam int ROW_W = NUM_REGS * DATA_W;

    hdrState_t          state;
    hdrState_t          nextState;
    logic [LAYER_W-1:0] idx;
    logic [LAYER_W-1:0] nextIdx;
    logic               rearm;
    logic               nextRearm;
    logic               wrOk;
    logic               copyEn;
    logic [ROW_W-1:0]   shadowRow;
    logic [ROW_W-1:0]   activeRow;

    assign wrOk = wr_en
               && (int'(wr_layer) < NUM_LAYERS)
               && (int'(wr_reg) < NUM_REGS);

    assign copyEn = (state == COPY) && dirty[idx];

    layer_header_bank #(
        .NUM_LAYERS(NUM_LAYERS),
        .NUM_REGS  (NUM_REGS),
        .DATA_W    (DATA_W)
    ) shadowBank (
        .clk     (clk),
        .reset   (reset),
        .regWrEn (wrOk),
        .regLayer(wr_layer),
        .regIdx  (wr_reg),
        .regData (wr_data),
        .rowWrEn (1'b0),
        .rowLayer(idx),
        .rowData ('0),
        .rdLayer (idx),
        .rdRow   (shadowRow)
    );

    // Copy reads the registered shadow row, so a same-cycle host write
    // is not part of this copy and leaves the layer dirty.
    layer_header_bank #(
        .NUM_LAYERS(NUM_LAYERS),
        .NUM_REGS  (NUM_REGS),
        .DATA_W    (DATA_W)
    ) activeBank (
        .clk     (clk),
        .reset   (reset),
        .regWrEn (1'b0),
        .regLayer('0),
        .regIdx  ('0),
        .regData ('0),
        .rowWrEn (copyEn),
        .rowLayer(idx),
        .rowData (shadowRow),
        .rdLayer (rd_layer),
        .rdRow   (activeRow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            rearm <= 1'b0;
        end else begin
            state <= nextState;
            idx   <= nextIdx;
            rearm <= nextRearm;
        end
    end

    always_comb begin
        nextState = state;
        nextIdx   = idx;
        nextRearm = rearm;
        unique case (state)
            IDLE: begin
                if (commit_req) nextState = ARMED;
            end
            ARMED: begin
                if (frame_start) begin
                    nextState = COPY;
                    nextIdx   = '0;
                end
            end
            COPY: begin
                if (commit_req) nextRearm = 1'b1;
                if (int'(idx) == NUM_LAYERS - 1) begin
                    nextState = DONE;
                end else begin
                    nextIdx = idx + LAYER_W'(1);
                end
            end
            DONE: begin
                nextState = (rearm || commit_req) ? ARMED : IDLE;
                nextRearm = 1'b0;
            end
            default: nextState = IDLE;
        endcase
    end

    // A host write in the copy cycle must win over the copy's clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            dirty <= '0;
        end else begin
            if (copyEn) dirty[idx] <= 1'b0;
            if (wrOk) dirty[wr_layer] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= activeRow;
        end
    end

    assign commit_pending = (state == ARMED) || (state == COPY);
    assign commit_done    = (state == DONE);

endmodule

// File: doc/layer_header_shadow_regs.md
Name: layer_header_shadow_regs

Overview:
Parametrised, double-buffered successor to the GPU engine's layer header register storage. Host writes go to a shadow bank. On a host commit request, dirty layers are copied into the active bank at the next frame boundary, so the renderer never sees a half-updated header mid-frame. The renderer reads one layer's full header through a registered read port with a valid flag.

Parameters:
NUM_LAYERS, 32, number of layers (≥2, need not be a power of 2)
NUM_REGS, 8, header registers per layer (≥1)
DATA_W, 16, bits per header register
LAYER_W, $clog2(NUM_LAYERS), derived localparam, layer index width
REG_W, max(1,$clog2(NUM_REGS)), derived localparam, register index width

Ports:
clk  in  1  master clock, all logic on rising edge
reset  in  1  synchronous, active-high (1 = reset, 0 = run)
wr_en  in  1  shadow write strobe
wr_layer  in  LAYER_W  layer to write
wr_reg  in  REG_W  register index within layer
wr_data  in  DATA_W  write data
commit_req  in  1  pulse: arm shadow→active copy
frame_start  in  1  pulse: frame boundary from video timing
commit_pending  out  1  high while armed or copying
commit_done  out  1  one-cycle pulse when copy completes
rd_en  in  1  read request
rd_layer  in  LAYER_W  layer to read
rd_valid  out  1  rd_data valid, one cycle after rd_en
rd_data  out  NUM_REGS*DATA_W  active header; register r occupies bits [r*DATA_W +: DATA_W]
dirty  out  NUM_LAYERS  per-layer flag: shadow differs from active (written since last copy)

Behaviour:
- Reset (sync, has priority over everything): both banks zeroed, dirty=0, state IDLE, rd_valid=0, rd_data=0, commit_pending=0, commit_done=0.
- Shadow write: when wr_en is high, shadow[wr_layer][wr_reg] <= wr_data and dirty[wr_layer] <= 1 at the edge. Writes with wr_layer ≥ NUM_LAYERS or wr_reg ≥ NUM_REGS are dropped with no dirty change.
- Read: rd_en at cycle t → rd_valid=1 and rd_data=active[rd_layer] at cycle t+1 (latency 1).
  - Without rd_en, rd_valid=0 and rd_data holds its last value.
  - rd_layer ≥ NUM_LAYERS returns all-zero data with rd_valid=1.
- FSM states:
  - IDLE: commit_req → ARMED. frame_start is ignored.
  - ARMED: frame_start → COPY with idx=0. Further commit_req has no effect.
  - COPY: lasts exactly NUM_LAYERS cycles, one layer per cycle.
    - If dirty[idx], active[idx] <= shadow[idx] and dirty[idx] <= 0; otherwise no change.
    - idx increments each cycle; after idx=NUM_LAYERS-1 → DONE.
  - DONE: one cycle, commit_done=1, then → ARMED if rearm is set, else IDLE. rearm is cleared on leaving DONE.
- commit_pending = (state==ARMED || state==COPY).
- commit_req and frame_start in the same cycle while IDLE: arms only; the copy waits for the next frame_start.
- commit_req during COPY or DONE sets rearm.
- Write to layer idx in the same cycle it is copied: the copy takes the pre-write shadow value, the write lands in shadow, and dirty[idx] stays 1.
- Read of layer idx in the same cycle it is copied returns the pre-copy active value. The new value is visible from the next cycle.
- reset during ARMED or COPY: copy aborted, all state cleared, no commit_done pulse.

Decomposition:
- Package layer_hdr_pkg holds:
  - the FSM state enum (IDLE, ARMED, COPY, DONE);
  - named register index constants for the default 8-register header: LAYER_REG_CTRL, LAYER_REG_ADDR_LO, LAYER_REG_ADDR_HI, LAYER_REG_X, LAYER_REG_Y, LAYER_REG_W, LAYER_REG_H, LAYER_REG_ALPHA = 0..7.
- One sub-module, layer_header_bank, is instantiated twice (shadow, active):
  - storage of NUM_LAYERS × (NUM_REGS*DATA_W) with reset clear;
  - per-register write port, full-row write port, full-row combinational read.
- The top level holds the FSM, dirty vector, rearm flag and read register.

Test Plan:
- Reset, then rd_en layer 5 → rd_valid=1 next cycle, rd_data=0, dirty=0, commit_pending=0.
- Write layer 3 reg 2 = 0xBEEF, read layer 3 → data 0 (active untouched) and dirty[3]=1. Then commit_req, then frame_start → commit_pending high for 1+NUM_LAYERS cycles, commit_done pulses once 33 cycles after frame_start. Read layer 3 → bits[47:32]=0xBEEF, dirty[3]=0.
- frame_start with no prior commit_req after writing layer 7 = 0x1234 → no copy, no commit_done, active layer 7 still 0.
- During COPY, wr to layer 0 (reg 0 = 0xAAAA) in the cycle idx=0 plus commit_req → dirty[0] stays 1. After DONE the FSM returns to ARMED, and the next frame_start copies 0xAAAA.
- During COPY, write to layer 20 while idx=10 → the new value is copied at idx=20 in the same pass and dirty[20]=0 after DONE.
- Assert reset mid-COPY (idx=12) → no commit_done, all reads return 0, dirty=0, state IDLE. Write to wr_layer 31, reg 7 with NUM_REGS=6 → dropped, dirty unchanged.
